alif_param_loader: RTL
======================

ALIF_PARAM_LOADER -- requirements
Module: alif_param_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: enable  input  1  global enable; low freezes all state, no sampling.
REQ-004 SHALL have port: load_mode  input  1  high = configuration frame in progress.
REQ-005 SHALL have port: serial_data  input  1  serial frame bit, MSB first.
REQ-006 SHALL have ports: threshold  output  8; leak_exc  output  4; leak_inh  output  4; adapt_inc  output  4; adapt_decay  output  4; refrac  output  4; w_scale_a  output  2; w_scale_b  output  2. Committed neuron parameters.
REQ-007 SHALL have port: params_ready  output  1  high = last frame committed and parameters valid.
REQ-008 SHALL have port: load_busy  output  1  high in SHIFT or COMMIT.
REQ-009 SHALL have port: load_error  output  1  sticky: last frame was rejected.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, COMMIT, WAIT_LOW.
REQ-011 SHALL sample serial_data only on edges where enable=1 and load_mode=1 in IDLE or SHIFT.
REQ-012 IDLE with load_mode=1 SHALL sample bit 0, set count=1, clear params_ready and load_error, and go to SHIFT.
REQ-013 SHALL use payload layout (first bit = bit 31): [31:24] threshold, [23:20] leak_exc, [19:16] leak_inh, [15:12] adapt_inc, [11:8] adapt_decay, [7:4] refrac, [3:2] w_scale_a, [1:0] w_scale_b.
REQ-014 After sampling the final frame bit, SHALL go to COMMIT; on the next edge it SHALL update all parameter outputs from the shadow register, set params_ready=1, and go to WAIT_LOW (one cycle of latency after the last bit).
REQ-015 In SHIFT, load_mode=0 before the frame is complete SHALL abort: shadow discarded, outputs unchanged, load_error=1, params_ready=0, go to IDLE.
REQ-016 WAIT_LOW SHALL ignore serial_data until load_mode=0, then go to IDLE; extra bits SHALL never alter outputs.
REQ-017 Parameter outputs SHALL change only in COMMIT; they are never partially updated.
REQ-018 With enable=0, FSM, bit counter and shadow SHALL hold; resuming continues the frame at the same bit index.

Reset
REQ-019 reset SHALL asynchronously force IDLE, count=0, shadow=0, params_ready=0, load_busy=0, load_error=0.
REQ-020 reset SHALL load defaults: threshold=100, leak_exc=2, leak_inh=2, adapt_inc=4, adapt_decay=1, refrac=3, w_scale_a=1, w_scale_b=1.
REQ-021 reset mid-frame SHALL discard the partial frame and restore defaults.

Configuration
REQ-022 SHALL support macro ALIF_LOADER_CHECKSUM_EN.
REQ-023 Without the macro, frame = 32 payload bits, always committed when complete.
REQ-024 With the macro, frame = 40 bits: 32 payload bits, then an 8-bit checksum (MSB first) equal to the XOR of the four payload bytes.
REQ-025 With the macro, on checksum mismatch COMMIT SHALL leave outputs unchanged, set load_error=1, keep params_ready=0, and go to WAIT_LOW.

Structure
REQ-026 Package alif_pkg SHALL hold the field widths, field bit offsets, reset defaults, frame lengths (32/40), and the FSM state enum.
REQ-027 Sub-module alif_shift_deser (shift register + 6-bit bit counter, MSB-first) SHALL be instantiated; FSM and commit logic stay in alif_param_loader.

Verification
REQ-028 Reset release, no load -> outputs equal the REQ-020 defaults, params_ready=0, load_error=0.
REQ-029 Frame 0xC8_35_72_A6 (plus checksum 0x29 if the macro is defined) -> one cycle after the last bit: threshold=200, leak_exc=3, leak_inh=5, adapt_inc=7, adapt_decay=2, refrac=10, w_scale_a=1, w_scale_b=2, params_ready=1.
REQ-030 load_mode dropped after 17 bits -> outputs keep their prior values, load_error=1, params_ready=0, state IDLE.
REQ-031 enable=0 for 5 cycles mid-frame while serial_data toggles -> the committed frame equals one sent without the gap.
REQ-032 Macro defined, payload 0xC8_35_72_A6 with checksum 0x00 -> no update, load_error=1; a following valid frame clears load_error and commits.
REQ-033 reset asserted at bit 20 -> immediate defaults, IDLE; the next complete frame commits normally.

Source files
------------

// File: rtl/alif_pkg.sv
// Shared field layout, reset defaults, frame lengths and FSM states for the ALIF parameter loader.
// Frame length depends on ALIF_LOADER_CHECKSUM_EN (adds an 8-bit XOR checksum after the payload).
package alif_pkg;

    localparam int THR_W    = 8;
    localparam int LEAK_W   = 4;
    localparam int ADAPT_W  = 4;
    localparam int REFRAC_W = 4;
    localparam int WS_W     = 2;

    localparam int THR_OFF         = 24;
    localparam int LEAK_EXC_OFF    = 20;
    localparam int LEAK_INH_OFF    = 16;
    localparam int ADAPT_INC_OFF   = 12;
    localparam int ADAPT_DECAY_OFF = 8;
    localparam int REFRAC_OFF      = 4;
    localparam int WS_A_OFF        = 2;
    localparam int WS_B_OFF        = 0;

    localparam int PAYLOAD_LEN     = 32;
    localparam int CKSUM_LEN       = 8;
    localparam int FRAME_LEN_PLAIN = 32;
    localparam int FRAME_LEN_CKSUM = 40;
`ifdef ALIF_LOADER_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CKSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_LOW} state_e;

    typedef struct packed {
        logic [THR_W-1:0]    threshold;
        logic [LEAK_W-1:0]   leak_exc;
        logic [LEAK_W-1:0]   leak_inh;
        logic [ADAPT_W-1:0]  adapt_inc;
        logic [ADAPT_W-1:0]  adapt_decay;
        logic [REFRAC_W-1:0] refrac;
        logic [WS_W-1:0]     w_scale_a;
        logic [WS_W-1:0]     w_scale_b;
    } params_t;

    localparam params_t PARAMS_DEFAULT = '{
        threshold:   8'd100,
        leak_exc:    4'd2,
        leak_inh:    4'd2,
        adapt_inc:   4'd4,
        adapt_decay: 4'd1,
        refrac:      4'd3,
        w_scale_a:   2'd1,
        w_scale_b:   2'd1
    };

    function automatic params_t unpack_payload(input logic [PAYLOAD_LEN-1:0] p);
        params_t r;
        r.threshold   = p[THR_OFF +: THR_W];
        r.leak_exc    = p[LEAK_EXC_OFF +: LEAK_W];
        r.leak_inh    = p[LEAK_INH_OFF +: LEAK_W];
        r.adapt_inc   = p[ADAPT_INC_OFF +: ADAPT_W];
        r.adapt_decay = p[ADAPT_DECAY_OFF +: ADAPT_W];
        r.refrac      = p[REFRAC_OFF +: REFRAC_W];
        r.w_scale_a   = p[WS_A_OFF +: WS_W];
        r.w_scale_b   = p[WS_B_OFF +: WS_W];
        return r;
    endfunction

    function automatic logic [CKSUM_LEN-1:0] payload_xor(input logic [PAYLOAD_LEN-1:0] p);
        return p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

endpackage

// File: rtl/alif_shift_deser.sv
// MSB-first serial-to-parallel shift register with a bit counter.
// start loads the first bit (count=1), shift appends a bit, clear zeroes both.
module alif_shift_deser #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             shift,
    input  logic             clear,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (start) begin
            shreg_d = {{(WIDTH-1){1'b0}}, bit_in};
            cnt_d   = CNT_W'(1);
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], bit_in};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data  = shreg_q;
    assign count = cnt_q;
endmodule

// File: rtl/alif_param_loader.sv
// Serial configuration loader for ALIF neuron parameters: shifts a frame in, commits it atomically.
// Define ALIF_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before committing.
module alif_param_loader
    import alif_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load_mode,
    input  logic                serial_data,
    output logic [THR_W-1:0]    threshold,
    output logic [LEAK_W-1:0]   leak_exc,
    output logic [LEAK_W-1:0]   leak_inh,
    output logic [ADAPT_W-1:0]  adapt_inc,
    output logic [ADAPT_W-1:0]  adapt_decay,
    output logic [REFRAC_W-1:0] refrac,
    output logic [WS_W-1:0]     w_scale_a,
    output logic [WS_W-1:0]     w_scale_b,
    output logic                params_ready,
    output logic                load_busy,
    output logic                load_error
);
    state_e  state_q, state_d;
    params_t params_q, params_d;
    logic    ready_q, ready_d;
    logic    busy_q, busy_d;
    logic    error_q, error_d;

    logic                   ds_start, ds_shift, ds_clear;
    logic [FRAME_LEN-1:0]   ds_data;
    logic [CNT_W-1:0]       ds_count;
    logic [PAYLOAD_LEN-1:0] payload;
    logic                   cksum_ok;

    alif_shift_deser #(
        .WIDTH (FRAME_LEN),
        .CNT_W (CNT_W)
    ) u_deser (
        .clk    (clk),
        .reset  (reset),
        .start  (ds_start),
        .shift  (ds_shift),
        .clear  (ds_clear),
        .bit_in (serial_data),
        .data   (ds_data),
        .count  (ds_count)
    );

    assign payload = ds_data[FRAME_LEN-1 -: PAYLOAD_LEN];

`ifdef ALIF_LOADER_CHECKSUM_EN
    assign cksum_ok = (ds_data[CKSUM_LEN-1:0] == payload_xor(payload));
`else
    assign cksum_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        params_d = params_q;
        ready_d  = ready_q;
        error_d  = error_q;
        ds_start = 1'b0;
        ds_shift = 1'b0;
        ds_clear = 1'b0;
        // Everything, including the deserializer, freezes while enable is low.
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (load_mode) begin
                        ds_start = 1'b1;
                        ready_d  = 1'b0;
                        error_d  = 1'b0;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (load_mode) begin
                        ds_shift = 1'b1;
                        if (ds_count == CNT_W'(FRAME_LEN - 1)) begin
                            state_d = COMMIT;
                        end
                    end else begin
                        ds_clear = 1'b1;
                        error_d  = 1'b1;
                        ready_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end
                COMMIT: begin
                    ds_clear = 1'b1;
                    state_d  = WAIT_LOW;
                    if (cksum_ok) begin
                        params_d = unpack_payload(payload);
                        ready_d  = 1'b1;
                    end else begin
                        error_d  = 1'b1;
                        ready_d  = 1'b0;
                    end
                end
                WAIT_LOW: begin
                    if (!load_mode) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == SHIFT) || (state_d == COMMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            params_q <= PARAMS_DEFAULT;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            params_q <= params_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    assign threshold    = params_q.threshold;
    assign leak_exc     = params_q.leak_exc;
    assign leak_inh     = params_q.leak_inh;
    assign adapt_inc    = params_q.adapt_inc;
    assign adapt_decay  = params_q.adapt_decay;
    assign refrac       = params_q.refrac;
    assign w_scale_a    = params_q.w_scale_a;
    assign w_scale_b    = params_q.w_scale_b;
    assign params_ready = ready_q;
    assign load_busy    = busy_q;
    assign load_error   = error_q;
endmodule
